// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if
// Data-bus link between a CPU core (master) and a memory responder (slave).
//   dreq_valid      master -> slave  request present
//   dreq_addr[31:0] master -> slave  byte address
//   dreq_size[2:0]  master -> slave  access size (not interpreted by the SRAM model)
//   dreq_strobe[3:0]master -> slave  byte-lane write enables, 0 = read
//   dreq_data[31:0] master -> slave  write data
//   dresp_addr_ok   slave -> master  request accepted this cycle
//   dresp_data_ok   slave -> master  response valid this cycle
//   dresp_data[31:0]slave -> master  read data (old word for writes)
interface dbus_sram_responder_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder
// Word-organised single-port SRAM acting as the data-bus responder. Accepts one
// request at a time, answers after a fixed LATENCY with the word read before
// any write (read-old), and commits strobed writes at the end of the response
// cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (control state only, memory kept)
//   dbus   slave side of dbus_sram_responder_if
// Parameters:
//   DEPTH    memory size in 32-bit words (power of two, >= 2)
//   LATENCY  cycles from accept to data_ok (1..15)
module dbus_sram_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  dbus_sram_responder_if.slave dbus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic [3:0]      strb_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            addr_ok;
  logic            data_ok;
  logic [31:0]     rdata;

  // Size, sub-word offset and address bits above the array are don't-care.
  logic unused_req;
  assign unused_req = ^{dbus.dreq_size, dbus.dreq_addr[1:0], dbus.dreq_addr[31:AW+2]};

  assign accept = (state_q == IDLE) && dbus.dreq_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dbus.dreq_valid) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter holds cycles still to wait before RESP, so 1 means RESP is next.
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    addr_ok = accept;
    data_ok = (state_q == RESP);
    rdata   = data_ok ? mem[idx_q] : 32'd0;
  end

  assign dbus.dresp_addr_ok = addr_ok;
  assign dbus.dresp_data_ok = data_ok;
  assign dbus.dresp_data    = rdata;

  // Request capture; only meaningful while a request is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= dbus.dreq_addr[AW+1:2];
      strb_q  <= dbus.dreq_strobe;
      wdata_q <= dbus.dreq_data;
    end
  end

  // Write commits on the edge that closes RESP. An async reset during the
  // request forces IDLE first, so a dropped request never reaches this edge.
  always_ff @(posedge clk) begin
    if (state_q == RESP) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
